mimo_frame_loader: RTL
======================

Name: mimo_frame_loader

Overview:
- Parametrised successor to the MIMO detector input interface: accepts a streamed frame of complex channel matrix H (NANT x NANT) and receive vector y (NANT) over LANES words per beat.
- Builds the real-valued 2NANT x 2NANT H and 2NANT y, then presents them to the detector through a valid/ready register stage.
- Adds input and output handshakes, frame-start alignment, error flagging and back-pressure, which the fixed 14-cycle loader does not have.
- Sits between the sample-input pins and MIMOdetector.

Parameters:
- IN_WL, 16, input word width (two's complement).
- WL, 16, output element width; IN_WL <= WL is required.
- NANT, 4, antenna count; H is NANT x NANT complex.
- LANES, 3, input words per beat.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  input beat valid
- in_sof  in  1  marks first beat of a frame
- in_data  in  LANES*IN_WL  lane k at bits [k*IN_WL +: IN_WL]
- in_ready  out  1  loader can accept a beat
- out_valid  out  1  H_o/Y_o hold a complete frame
- out_ready  in  1  detector consumes the frame
- H_o  out  4*NANT*NANT*WL  element (p,q) at [(p*2NANT+q)*WL +: WL]
- Y_o  out  2*NANT*WL  element p at [p*WL +: WL]
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Frame word order, with word index w = beat*LANES + lane:
  - H row-major, each entry as re then im: words 0 .. 2NANT^2-1.
  - Then y as re, im per antenna: 2NANT words.
- Total WORDS = 2NANT(NANT+1). BEATS = ceil(WORDS/LANES); defaults give 40 words in 14 beats. Unused lanes of the last beat are ignored.
- A beat is accepted when in_valid && in_ready.
- Real expansion: complex entry (r,c) = a+jb maps to the block H[2r][2c]=a, H[2r][2c+1]=-b, H[2r+1][2c]=b, H[2r+1][2c+1]=a. y_r = a+jb maps to Y[2r]=a, Y[2r+1]=b.
- Width rules:
  - Every word is sign-extended from IN_WL to WL.
  - Negation saturates: -(-2^(WL-1)) gives 2^(WL-1)-1. This only matters when WL == IN_WL.
- States:
  - IDLE: in_ready=1. An accepted beat with in_sof goes to FILL with beat_cnt=1. An accepted beat without in_sof is dropped and frame_err pulses.
  - FILL: in_ready=1. Each accepted beat increments beat_cnt.
    - An accepted beat with in_sof aborts the partial frame: it restarts as beat 0, beat_cnt=1, and frame_err pulses.
    - When the beat with beat_cnt == BEATS-1 is accepted, the frame is complete:
      - If the output stage is free (out_valid==0 || out_ready), transfer to H_o/Y_o on the next edge and go to IDLE.
      - Otherwise go to HOLD.
  - HOLD: in_ready=0. When out_ready=1, transfer on that edge and go to IDLE.
- Output stage:
  - out_valid rises the cycle after transfer.
  - out_valid clears on out_valid && out_ready unless a new transfer happens on the same edge, in which case it stays 1 with the new data.
  - H_o/Y_o are stable while out_valid && !out_ready.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+1 when the output stage is free.
- Throughput: one frame per BEATS cycles with out_ready held high; there are no bubbles between frames.
- Reset: when rst=0 at a clk edge:
  - state=IDLE, beat_cnt=0, in_ready=1 (after the edge), out_valid=0, H_o=0, Y_o=0, frame_err=0.
  - Any partial or held frame is discarded, including when reset lands mid-FILL or in HOLD.
- in_valid=0 cycles inside FILL are legal; the count freezes.

Test Plan:
- Defaults, stream words w=1..40 over 14 back-to-back beats, in_sof on beat 0, out_ready=1 -> out_valid high exactly one cycle after beat 13; first entry a=1, b=2 gives H_o(0,0)=1, (0,1)=-2, (1,0)=2, (1,1)=1; Y_o(0)=33, Y_o(7)=40.
- Two frames back-to-back with out_ready=0 until cycle 30 -> first frame held stable; second frame reaches HOLD after beat 27 with in_ready=0; out_ready at cycle 30 -> second frame appears on the next edge, in_ready returns to 1.
- in_sof asserted on beat 6 of a frame -> frame_err pulses one cycle; frame completes 14 beats after the restart; no output from the aborted frame.
- Beat without in_sof in IDLE -> dropped, frame_err pulse, next in_sof frame loads correctly.
- WL=IN_WL=16, im word = -32768 -> negated element = 32767.
- rst=0 for one edge at beat 9 -> out_valid=0 and outputs 0; a fresh 14-beat frame then loads correctly; NANT=2, LANES=4 build -> 12 words in 3 beats, correct 4x4 H_o.

Source files
------------

// File: rtl/mimo_frame_loader.sv
// mimo_frame_loader
// Collects a streamed complex frame (H row-major as re/im pairs, then y as
// re/im pairs), LANES words per beat, and presents the real-valued expansion
// (2NANT x 2NANT H, 2NANT y) to the detector through a valid/ready register.
// IN_WL must not exceed WL.
//
// Handshakes:
//   input : a beat is taken on any edge where in_valid && in_ready; in_ready
//           depends only on state (low only while a finished frame waits).
//   output: H_o/Y_o/out_valid form a register stage; the frame is consumed on
//           an edge where out_valid && out_ready, and H_o/Y_o do not change
//           while out_valid && !out_ready.
module mimo_frame_loader #(
    parameter int IN_WL = 16,
    parameter int WL    = 16,
    parameter int NANT  = 4,
    parameter int LANES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [LANES*IN_WL-1:0]    in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NANT*NANT*WL-1:0] H_o,
    output logic [2*NANT*WL-1:0]      Y_o,
    output logic                      frame_err,
    output logic [1:0]                dbg_state_o
);

    localparam int N2    = 2 * NANT;
    localparam int WORDS = N2 * (NANT + 1);
    localparam int BEATS = (WORDS + LANES - 1) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [WL-1:0] MIN_VAL = {1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] MAX_VAL = {1'b0, {(WL-1){1'b1}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic                      xfer_q, xfer_d;
    logic                      err_q, err_d;
    logic                      out_valid_q;
    logic [WORDS*IN_WL-1:0]    frame_q;
    logic [4*NANT*NANT*WL-1:0] H_q, H_d;
    logic [2*NANT*WL-1:0]      Y_q, Y_d;

    logic             accept;
    logic             wr_en;
    logic             out_free;
    logic             load;
    logic [CNT_W-1:0] beat_idx;

    function automatic logic [WL-1:0] sext(input logic [IN_WL-1:0] w);
        logic signed [IN_WL-1:0] s;
        s = w;
        return WL'(s);
    endfunction

    // The most negative value has no positive twin; clamp it to the maximum.
    function automatic logic [WL-1:0] neg_sat(input logic [WL-1:0] v);
        if (v == MIN_VAL) return MAX_VAL;
        return -v;
    endfunction

    assign in_ready    = (state_q != S_HOLD);
    assign accept      = in_valid && in_ready;
    // A beat carrying in_sof always lands as beat 0, even mid-frame.
    assign beat_idx    = in_sof ? '0 : beat_cnt_q;
    // Beats without in_sof outside a frame are discarded.
    assign wr_en       = accept && (in_sof || state_q == S_FILL);
    // A transfer already scheduled for the next edge occupies the stage.
    assign out_free    = !xfer_q && (!out_valid_q || out_ready);
    assign load        = xfer_q || (state_q == S_HOLD && out_ready);

    assign out_valid   = out_valid_q;
    assign H_o         = H_q;
    assign Y_o         = Y_q;
    assign frame_err   = err_q;
    assign dbg_state_o = state_q;

    // Frame FSM: beat counting, abort/drop detection, completion routing.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        xfer_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    if (!wr_en) begin
                        err_d = 1'b1;
                    end else begin
                        if (in_sof && state_q == S_FILL) err_d = 1'b1;
                        if (beat_idx == LAST_BEAT) begin
                            beat_cnt_d = '0;
                            if (out_free) begin
                                xfer_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            beat_cnt_d = beat_idx + 1'b1;
                            state_d    = S_FILL;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            xfer_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            xfer_q     <= xfer_d;
            err_q      <= err_d;
        end
    end

    // Raw word buffer; lanes beyond the last word of the frame are ignored.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int w = 0; w < WORDS; w++) begin
                if (CNT_W'(w / LANES) == beat_idx) begin
                    frame_q[w*IN_WL +: IN_WL] <= in_data[(w % LANES)*IN_WL +: IN_WL];
                end
            end
        end
    end

    // Complex-to-real expansion of the buffered frame.
    always_comb begin
        H_d = '0;
        Y_d = '0;
        for (int r = 0; r < NANT; r++) begin
            for (int c = 0; c < NANT; c++) begin
                logic [WL-1:0] a;
                logic [WL-1:0] b;
                a = sext(frame_q[(2*(r*NANT + c))*IN_WL +: IN_WL]);
                b = sext(frame_q[(2*(r*NANT + c) + 1)*IN_WL +: IN_WL]);
                H_d[((2*r)*N2 + 2*c)*WL +: WL]         = a;
                H_d[((2*r)*N2 + 2*c + 1)*WL +: WL]     = neg_sat(b);
                H_d[((2*r + 1)*N2 + 2*c)*WL +: WL]     = b;
                H_d[((2*r + 1)*N2 + 2*c + 1)*WL +: WL] = a;
            end
        end
        for (int r = 0; r < NANT; r++) begin
            Y_d[(2*r)*WL +: WL]     = sext(frame_q[(2*N2*NANT/2 + 2*r)*IN_WL +: IN_WL]);
            Y_d[(2*r + 1)*WL +: WL] = sext(frame_q[(2*N2*NANT/2 + 2*r + 1)*IN_WL +: IN_WL]);
        end
    end

    // Output register stage; a load on the consuming edge keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            H_q         <= '0;
            Y_q         <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            H_q         <= H_d;
            Y_q         <= Y_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
